// File: rtl/bcd_scan_decoder.sv
// -----------------------------------------------------------------------------
// bcd_scan_decoder
//
// Buffers a packed word of DIGITS BCD nibbles and scans it out one digit at a
// time. Each digit is shown as a registered one-hot 10-line decimal code, and
// a one-hot digit select is held for SCAN_DIV cycles per digit. Codes 10..15
// are flagged instead of being decoded.
//
// Parameters
//   DIGITS    number of BCD digits in the input word (>= 1)
//   SCAN_DIV  cycles each digit is held on the outputs (>= 1)
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_bcd carries a word to load
//   in_ready   a word can be accepted this cycle
//   in_bcd     packed BCD, digit k = in_bcd[4k+3:4k], digit 0 least significant
//   dec_out    one-hot decimal of the current digit, zero for bad codes / idle
//   digit_sel  one-hot select of the current digit, zero when idle
//   digit_idx  binary index of the current digit
//   err_digit  current digit's code is 10..15
//   err_frame  loaded word holds at least one bad digit (sticky until the
//              next accept)
//   done       one-cycle pulse on the last cycle of a frame
//
// Build option
//   BCD_SCAN_REPEAT_EN  when defined, the block refreshes continuously: after
//                       the last digit it wraps to digit 0 and stays in SCAN.
//                       in_ready is high in IDLE and in the last cycle of each
//                       frame, where an accept swaps in the new word with no
//                       gap. When undefined, each accepted word is scanned
//                       once and the block returns to IDLE.
// -----------------------------------------------------------------------------
module bcd_scan_decoder #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 4,
   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_bcd,
   output logic [9:0]            dec_out,
   output logic [DIGITS-1:0]     digit_sel,
   output logic [IDX_W-1:0]      digit_idx,
   output logic                  err_digit,
   output logic                  err_frame,
   output logic                  done
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } state_t;

   // ---------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------
   state_t                state_q, state_d;
   logic [4*DIGITS-1:0]   word_q, word_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_frame_q, err_frame_d;

   logic [9:0]            dec_out_q, dec_out_d;
   logic [DIGITS-1:0]     digit_sel_q, digit_sel_d;
   logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
   logic                  err_digit_q, err_digit_d;
   logic                  done_q, done_d;
   logic                  in_ready_q, in_ready_d;

   // ---------------------------------------------------------------------
   // Per-digit helpers
   // ---------------------------------------------------------------------
   logic [DIGITS-1:0]     bad_in;      // incoming digit is 10..15
   logic [3:0]            nib_d [DIGITS];
   logic [DIGITS-1:0]     sel_lines;
   logic [9:0]            dec_lines;
   logic [3:0]            cur_code;
   logic                  accept;
   logic                  scan_d;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         // A nibble is >= 10 exactly when bit 3 is set together with bit 2 or bit 1.
         assign bad_in[gi]    = in_bcd[4*gi+3] & (in_bcd[4*gi+2] | in_bcd[4*gi+1]);
         assign nib_d[gi]     = word_d[4*gi +: 4];
         assign sel_lines[gi] = (idx_d == IDX_W'(gi));
      end

      // Codes 10..15 match none of the ten lines, so they decode to all-zero.
      for (genvar gi = 0; gi < 10; gi++) begin : g_dec
         assign dec_lines[gi] = (cur_code == 4'(gi));
      end
   endgenerate

   // The in_ready register mirrors "accepting this cycle", so the handshake is
   // qualified by the registered flag rather than by the state directly.
   assign accept   = in_valid & in_ready_q;

   // Outputs are decoded from the *next* word/index so that they appear in the
   // same cycle the state does, fully registered.
   assign cur_code = nib_d[idx_d];

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      err_frame_d = err_frame_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d     = S_SCAN;
               word_d      = in_bcd;
               idx_d       = '0;
               cnt_d       = '0;
               err_frame_d = |bad_in;
            end
         end

         S_SCAN: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
`ifdef BCD_SCAN_REPEAT_EN
                  // Frame boundary: either rescan the same word or take the
                  // offered one; the state stays in SCAN either way.
                  if (accept) begin
                     word_d      = in_bcd;
                     err_frame_d = |bad_in;
                  end
`else
                  state_d = S_IDLE;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registered output values
   // ---------------------------------------------------------------------
   always_comb begin
      scan_d      = (state_d == S_SCAN);
      dec_out_d   = '0;
      digit_sel_d = '0;
      digit_idx_d = '0;
      err_digit_d = 1'b0;
      done_d      = 1'b0;
      in_ready_d  = 1'b1;

      if (scan_d) begin
         dec_out_d   = dec_lines;
         digit_sel_d = sel_lines;
         digit_idx_d = idx_d;
         err_digit_d = (cur_code > 4'd9);
         done_d      = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
`ifdef BCD_SCAN_REPEAT_EN
         // Only the last cycle of a frame is open for a replacement word.
         in_ready_d  = done_d;
`else
         in_ready_d  = 1'b0;
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         word_q      <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         err_frame_q <= 1'b0;
         dec_out_q   <= '0;
         digit_sel_q <= '0;
         digit_idx_q <= '0;
         err_digit_q <= 1'b0;
         done_q      <= 1'b0;
         // Reset lands in IDLE, which is always open for a word.
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         err_frame_q <= err_frame_d;
         dec_out_q   <= dec_out_d;
         digit_sel_q <= digit_sel_d;
         digit_idx_q <= digit_idx_d;
         err_digit_q <= err_digit_d;
         done_q      <= done_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign dec_out   = dec_out_q;
   assign digit_sel = digit_sel_q;
   assign digit_idx = digit_idx_q;
   assign err_digit = err_digit_q;
   assign err_frame = err_frame_q;
   assign done      = done_q;

endmodule
